// File: rtl/imem_fetch_pkg.sv
// imem_pkg: shared constants, FSM state type and address helper for the
// imem read-side sequencer (imem_fetch) and its skid buffer.
package imem_pkg;

    localparam int AW         = 14;     // imem address width
    localparam int DW         = 16;     // imem data width
    localparam int LW         = 15;     // burst length width (0..16384)
    localparam int IMEM_DEPTH = 16384;  // words in the imem macro

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Next sequential imem address; the natural AW-bit overflow gives the
    // 16383 -> 0 wrap.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return a + {{(AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: valid/ready word stream from imem_fetch to the FIR datapath.
//   valid : word available (producer)
//   ready : consumer accepts the word
//   data  : word, stable while valid & !ready
//   last  : marks the final word of a burst
interface imem_fetch_if;
    import imem_pkg::*;

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/imem_fetch_skid_buf.sv
// imem_skid_buf: 2-entry FIFO holding captured imem words plus a per-entry
// last flag. The caller guarantees no push when full and no pop when empty.
//   push/push_data/push_last : write one entry at the tail
//   pop                      : retire the head entry
//   occ                      : current occupancy (0..2)
//   head_data/head_last      : head entry contents
module imem_skid_buf
    import imem_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head_data,
    output logic          head_last
);

    logic [DW-1:0] data_r [2];
    logic          last_r [2];
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    occ_r;

    // Entry storage and pointer/occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r[0] <= {DW{1'b0}};
            data_r[1] <= {DW{1'b0}};
            last_r[0] <= 1'b0;
            last_r[1] <= 1'b0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
        end else begin
            if (push) begin
                data_r[wr_ptr_r] <= push_data;
                last_r[wr_ptr_r] <= push_last;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign occ       = occ_r;
    assign head_data = data_r[rd_ptr_r];
    assign head_last = last_r[rd_ptr_r];

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: burst read sequencer for the 16K x 16 imem macro. A start
// request launches LENGTH sequential reads from BASE_ADDR; the 1-cycle-latency
// Q data is captured into a 2-entry skid buffer and streamed out over
// valid/ready. Reads are issued only when buffer space is guaranteed, so no
// word is lost under backpressure.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, base_addr, length    : burst request (sampled in IDLE)
//   busy, done                  : burst status; done is a one-cycle pulse
//   imem_cen/wen/a, imem_q      : imem read port (wen tied high)
//   out_if                      : word stream to the FIR datapath
module imem_fetch
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [LW-1:0]     length,
    output logic              busy,
    output logic              done,
    output logic              imem_cen,
    output logic              imem_wen,
    output logic [AW-1:0]     imem_a,
    input  logic [DW-1:0]     imem_q,
    imem_fetch_if.master      out_if
);

    localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

    fetch_state_e  state_r, state_nxt_s;
    logic [AW-1:0] addr_r;
    logic [LW-1:0] issue_cnt_r;
    logic          infl_r;
    logic          infl_last_r;
    logic          done_r;
    logic          busy_r;
    logic          done_nxt_s;
    logic          issue_s;
    logic          pop_s;
    logic          valid_s;
    logic [2:0]    credit_s;
    logic [1:0]    occ_s;
    logic [DW-1:0] head_data_s;
    logic          head_last_s;

    imem_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_r),
        .push_data (imem_q),
        .push_last (infl_last_r),
        .pop       (pop_s),
        .occ       (occ_s),
        .head_data (head_data_s),
        .head_last (head_last_s)
    );

    // Issue only if the word would still fit after this cycle's pop:
    // occ + infl - pop counts the slots already spoken for.
    always_comb begin
        valid_s  = (occ_s != 2'd0);
        pop_s    = valid_s & out_if.ready;
        credit_s = {1'b0, occ_s} + {2'b00, infl_r} - {2'b00, pop_s};
        if ((state_r == FETCH) && (issue_cnt_r != {LW{1'b0}}) && (credit_s <= 3'd1)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length != {LW{1'b0}}) begin
                        state_nxt_s = FETCH;
                    end else begin
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (issue_s && (issue_cnt_r == CNT_ONE)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DRAIN: begin
                // The last word is always captured after the final issue,
                // so its handshake can only happen here.
                if (pop_s && head_last_s) begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, address/issue counters, in-flight tracking and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            addr_r      <= {AW{1'b0}};
            issue_cnt_r <= {LW{1'b0}};
            infl_r      <= 1'b0;
            infl_last_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            infl_r      <= issue_s;
            infl_last_r <= issue_s & (issue_cnt_r == CNT_ONE);
            done_r      <= done_nxt_s;
            busy_r      <= (state_nxt_s != IDLE) | done_nxt_s;
            if ((state_r == IDLE) && start && (length != {LW{1'b0}})) begin
                addr_r      <= base_addr;
                issue_cnt_r <= length;
            end else if (issue_s) begin
                addr_r      <= addr_inc(addr_r);
                issue_cnt_r <= issue_cnt_r - CNT_ONE;
            end else begin
                addr_r      <= addr_r;
                issue_cnt_r <= issue_cnt_r;
            end
        end
    end

    assign imem_cen     = ~issue_s;
    assign imem_wen     = 1'b1;
    assign imem_a       = addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign out_if.valid = valid_s;
    assign out_if.data  = head_data_s;
    assign out_if.last  = head_last_s & valid_s;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: bursts push expected words/addresses into
// queues; a monitor compares every issued address and every accepted word.
module tb_imem_fetch;
    import imem_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy, done, imem_cen, imem_wen;
    logic [AW-1:0] imem_a;
    logic [DW-1:0] imem_q = 16'd0;

    imem_fetch_if ifc ();

    imem_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .imem_cen  (imem_cen),
        .imem_wen  (imem_wen),
        .imem_a    (imem_a),
        .imem_q    (imem_q),
        .out_if    (ifc.master)
    );

    always #5 clk = ~clk;

    // imem model: preloaded with addr+100, one-cycle read latency
    logic [DW-1:0] mem [0:IMEM_DEPTH-1];
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = DW'(i + 100);
    end
    always @(posedge clk) begin
        if (!imem_cen) imem_q <= mem[imem_a];
    end

    int checks = 0, failures = 0;
    int issued = 0, popped = 0, done_cnt = 0, last_cnt = 0;
    logic [16:0]   exp_q [$];
    logic [AW-1:0] addr_q [$];
    int ready_mode = 0, rdy_cyc = 0, pat_idx = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // consumer ready generator, updated just after each rising edge
    initial begin
        ifc.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cyc++;
            case (ready_mode)
                0: ifc.ready = 1'b1;
                1: begin ifc.ready = pat[pat_idx]; pat_idx = (pat_idx + 1) % 6; end
                2: ifc.ready = ($urandom_range(99, 0) < 70);
                3: begin
                    if (rdy_cyc < 12) ifc.ready = 1'b0;
                    else begin ifc.ready = pat[pat_idx]; pat_idx = (pat_idx + 1) % 6; end
                end
                default: ifc.ready = 1'b1;
            endcase
        end
    end

    // monitor: sampled on the falling edge, away from DUT updates
    initial begin
        logic pop_now, prev_stall, last_pop_prev;
        logic [DW-1:0] prev_data;
        logic [16:0] e;
        int outstanding;
        prev_stall = 1'b0; last_pop_prev = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                pop_now = ifc.valid && ifc.ready;
                outstanding = issued - popped;
                if (busy) chk("occ_bound", int'(outstanding <= 2), 1);
                if (!imem_cen) begin
                    if (addr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_issue: got addr %0d expected no issue", imem_a);
                    end else begin
                        chk("imem_a", int'(imem_a), int'(addr_q.pop_front()));
                    end
                    chk("imem_wen", int'(imem_wen), 1);
                    chk("credit", int'(outstanding - int'(pop_now) <= 1), 1);
                    issued++;
                end
                if (prev_stall) begin
                    chk("stall_valid", int'(ifc.valid), 1);
                    chk("stall_data", int'(ifc.data), int'(prev_data));
                end
                if (last_pop_prev) chk("done_after_last", int'(done), 1);
                if (pop_now) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_word: got %0d expected none", ifc.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", int'(ifc.data), int'(e[15:0]));
                        chk("out_last", int'(ifc.last), int'(e[16]));
                    end
                    popped++;
                    if (ifc.last) last_cnt++;
                end
                prev_stall    = ifc.valid && !ifc.ready;
                prev_data     = ifc.data;
                last_pop_prev = pop_now && ifc.last;
                if (done) done_cnt++;
            end else begin
                prev_stall    = 1'b0;
                last_pop_prev = 1'b0;
            end
        end
    end

    task automatic push_expect(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = b;
        for (int i = 0; i < len; i++) begin
            d = DW'(a) + 16'd100;
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), d});
            a = a + 14'd1;
        end
    endtask

    task automatic launch(input logic [AW-1:0] b, input int len);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input int len, input int mode,
                             input bit chk_lat, input int mid_at);
        int d0, l0, i0, cyc;
        push_expect(b, len);
        d0 = done_cnt; l0 = last_cnt; i0 = issued;
        ready_mode = mode; rdy_cyc = 0; pat_idx = 0;
        launch(b, len);
        if (len == 0) begin
            @(negedge clk);
            chk("zero_done", int'(done), 1);
        end
        if (chk_lat) begin
            @(negedge clk);
            chk("lat_e0_valid", int'(ifc.valid), 0);
            chk("busy_after_start", int'(busy), 1);
            @(negedge clk);
            chk("lat_e1_valid", int'(ifc.valid), 0);
            @(negedge clk);
            chk("lat_e2_valid", int'(ifc.valid), 1);
        end
        for (cyc = 0; cyc < len * 3 + 50 && done_cnt == d0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == mid_at) begin
                start = 1'b1; base_addr = 14'd500; length = 15'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", len * 3 + 50);
        end
        repeat (4) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("last_count", last_cnt - l0, (len > 0) ? 1 : 0);
        chk("issue_count", issued - i0, len);
        chk("words_left", exp_q.size(), 0);
        chk("busy_idle", int'(busy), 0);
        ready_mode = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_valid"}, int'(ifc.valid), 0);
        chk({tag, "_last"},  int'(ifc.last), 0);
        chk({tag, "_data"},  int'(ifc.data), 0);
        chk({tag, "_cen"},   int'(imem_cen), 1);
        chk({tag, "_wen"},   int'(imem_wen), 1);
        chk({tag, "_a"},     int'(imem_a), 0);
    endtask

    initial begin
        int p0, cyc;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        #2 rst_n = 1'b1;

        run_burst(14'd0,     8, 0, 1'b1, -1);   // basic burst
        run_burst(14'd16382, 4, 0, 1'b1, -1);   // address wrap
        run_burst(14'd10,    6, 1, 1'b1, -1);   // toggling backpressure
        run_burst(14'd300,   6, 3, 1'b1, -1);   // long stall then toggling
        run_burst(14'd20,    0, 0, 1'b0, -1);   // zero length
        run_burst(14'd1000,  6, 1, 1'b1, 3);    // start mid-burst ignored

        // asynchronous reset after 3 of 10 words
        push_expect(14'd200, 10);
        ready_mode = 0;
        p0 = popped;
        launch(14'd200, 10);
        for (cyc = 0; cyc < 100 && popped < p0 + 3; cyc++) begin
            @(negedge clk); #1;
        end
        chk("popped_before_reset", popped - p0, 3);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        exp_q.delete();
        addr_q.delete();
        issued = popped;
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_burst(14'd50, 2, 0, 1'b1, -1);

        // full memory sweep with random backpressure
        run_burst(14'd0, IMEM_DEPTH, 2, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
